jigsaw_axil_master: RTL

Single-outstanding AXI4-Lite initiator. It turns a simple command/response stream into AXI4-Lite write (AW/W/B) and read (AR/R) transactions. It drives the control-register slaves of the jigsaw vFPGA (MMIO vaddr, ctrl, status and PID registers) from on-chip sequencers and self-test logic. It sits between the jigsaw host-side controller and an AXI4-Lite slave port.

---
 rtl/jigsaw_axil_master.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/jigsaw_axil_master.sv
// jigsaw_axil_master
//
// Single-outstanding AXI4-Lite initiator. It converts a simple command/response
// stream into AXI4-Lite write (AW/W/B) and read (AR/R) transactions. It is used to
// drive the control-register slaves of the jigsaw vFPGA (MMIO vaddr, ctrl,
// status and PID registers) from on-chip sequencers and self-test logic.
//
// Ports
//   aclk, aresetn         clock; synchronous active-low reset
//   cmd_*                 command stream (valid/ready, wr, addr, wdata, wstrb)
//   rsp_*                 response stream (valid/ready, wr, rdata, resp)
//   m_aw*/m_w*/m_b*       AXI4-Lite write address / data / response channels
//   m_ar*/m_r*            AXI4-Lite read address / data channels
//   busy                  high whenever the FSM is not in IDLE
//   timeout_flag          sticky watchdog flag (only with the macro below)
//
// Build option
//   JIGSAW_AXIL_MASTER_TIMEOUT_EN : adds a watchdog that aborts a transaction
//   after TIMEOUT_CYC cycles with rsp_resp = 2'b11 and sets timeout_flag.
//   Without it the FSM waits indefinitely for the slave.

module jigsaw_axil_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AW channel
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // W channel
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // B channel
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // AR channel
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  // R channel
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  // status
  output logic                  busy
`ifdef JIGSAW_AXIL_MASTER_TIMEOUT_EN
  ,
  output logic                  timeout_flag
`endif
);

  localparam int STRB_W = DATA_W / 8;

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                wr_q, wr_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                rsp_wr_q, rsp_wr_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

`ifdef JIGSAW_AXIL_MASTER_TIMEOUT_EN
  logic [31:0]         cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                in_txn;
`endif

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wr_q        <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
`ifdef JIGSAW_AXIL_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wr_q        <= wr_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef JIGSAW_AXIL_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wr_d        = wr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          wr_d      = cmd_wr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_wr ? S_WR : S_RD_ADDR;
        end
      end
      S_WR: begin
        // A channel's valid is only high while its done flag is clear, so its
        // ready alone marks the handshake.
        aw_done_d = aw_done_q | m_awready;
        w_done_d  = w_done_q | m_wready;
        if (aw_done_d && w_done_d) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          rsp_resp_d  = m_bresp;
          rsp_rdata_d = '0;
          rsp_wr_d    = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RD_ADDR: begin
        if (m_arready) begin
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_rvalid) begin
          rsp_resp_d  = m_rresp;
          rsp_rdata_d = m_rdata;
          rsp_wr_d    = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef JIGSAW_AXIL_MASTER_TIMEOUT_EN
    timeout_d = timeout_q;
    in_txn    = state_q inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA};
    cnt_d     = cnt_q;
    if (state_q == S_IDLE && cmd_valid) begin
      cnt_d = '0;
    end else if (in_txn) begin
      cnt_d = cnt_q + 32'd1;
    end
    // A handshake that completes a phase on the last allowed cycle still wins;
    // the watchdog only fires when the FSM would otherwise stay put.
    if (in_txn && (cnt_q == 32'(TIMEOUT_CYC - 1)) && (state_d == state_q)) begin
      state_d     = S_RESP;
      rsp_resp_d  = 2'b11;
      rsp_rdata_d = '0;
      rsp_wr_d    = wr_q;
      timeout_d   = 1'b1;
    end
`endif
  end

  // Output decode
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    busy      = 1'b1;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WR: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
      end
      S_WR_RESP: m_bready  = 1'b1;
      S_RD_ADDR: m_arvalid = 1'b1;
      S_RD_DATA: m_rready  = 1'b1;
      S_RESP:    rsp_valid = 1'b1;
      default:   busy      = 1'b1;
    endcase

    m_awaddr  = addr_q;
    m_araddr  = addr_q;
    m_wdata   = wdata_q;
    m_wstrb   = wstrb_q;
    rsp_wr    = rsp_wr_q;
    rsp_rdata = rsp_rdata_q;
    rsp_resp  = rsp_resp_q;
  end

`ifdef JIGSAW_AXIL_MASTER_TIMEOUT_EN
  assign timeout_flag = timeout_q;
`endif

endmodule
